// File: rtl/snake_pkg.sv
// Shared constants and types for the snake game datapath.
// Screen geometry, coordinate/colour widths, colours, arbiter FSM states.
package snake_pkg;

    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int C_W = 3;

    localparam int SCREEN_XMAX = 159;
    localparam int SCREEN_YMAX = 119;

    localparam logic [C_W-1:0] COL_BLACK = 3'b000;
    localparam logic [C_W-1:0] COL_WHITE = 3'b111;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_t;

endpackage

// File: rtl/plot_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner selection.
// Ports: req, rr_last in; gnt_raw (one-hot), win (index), valid out.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_last,
    output logic [NREQ-1:0] gnt_raw,
    output logic [IW-1:0]   win,
    output logic            valid
);

    // Search starts one past the last winner and wraps.
    always_comb begin
        int j;
        j       = 0;
        gnt_raw = '0;
        win     = '0;
        valid   = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(rr_last) + k) % NREQ;
            if (!valid && req[j]) begin
                valid      = 1'b1;
                gnt_raw[j] = 1'b1;
                win        = IW'(j);
            end
        end
    end

endmodule

// File: rtl/plot_arbiter.sv
// plot_arbiter: shares the VGA pixel-write port among requesters (round-robin)
// and owns a full-screen clear engine. Ports: req/req_x/req_y/req_colour/gnt,
// clear_start/clear_colour/clear_busy/clear_done, x_out/y_out/colour_out/plot/drop.
import snake_pkg::*;

module plot_arbiter #(
    parameter int NREQ           = 4,
    parameter int XMAX           = SCREEN_XMAX,
    parameter int YMAX           = SCREEN_YMAX,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*X_W-1:0] req_x,
    input  logic [NREQ*Y_W-1:0] req_y,
    input  logic [NREQ*C_W-1:0] req_colour,
    output logic [NREQ-1:0]     gnt,
    input  logic                clear_start,
    input  logic [C_W-1:0]      clear_colour,
    output logic                clear_busy,
    output logic                clear_done,
    output logic [X_W-1:0]      x_out,
    output logic [Y_W-1:0]      y_out,
    output logic [C_W-1:0]      colour_out,
    output logic                plot,
    output logic                drop
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t     state;
    logic [X_W-1:0] cx;
    logic [Y_W-1:0] cy;
    logic [C_W-1:0] ccol;
    logic [IW-1:0]  rr_last;

    logic [NREQ-1:0] gnt_raw;
    logic [IW-1:0]   win;
    logic            win_valid;
    logic            grant_en;
    logic [X_W-1:0]  wx;
    logic [Y_W-1:0]  wy;
    logic [C_W-1:0]  wc;
    logic            oor;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req     (req),
        .rr_last (rr_last),
        .gnt_raw (gnt_raw),
        .win     (win),
        .valid   (win_valid)
    );

    // A clear request pre-empts any pending pixel in the same cycle.
    assign grant_en = (state == ST_RUN) && !clear_start;
    assign gnt      = gnt_raw & {NREQ{grant_en}};

    assign wx  = req_x[X_W*win +: X_W];
    assign wy  = req_y[Y_W*win +: Y_W];
    assign wc  = req_colour[C_W*win +: C_W];
    assign oor = (wx > X_W'(XMAX)) || (wy > Y_W'(YMAX));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clear_busy <= (CLEAR_ON_RESET != 0);
            cx         <= '0;
            cy         <= '0;
            ccol       <= COL_BLACK;
            rr_last    <= IW'(NREQ - 1);
            x_out      <= '0;
            y_out      <= '0;
            colour_out <= '0;
            plot       <= 1'b0;
            drop       <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            drop       <= 1'b0;
            unique case (state)
                ST_RUN: begin
                    if (clear_start) begin
                        state      <= ST_CLEAR;
                        clear_busy <= 1'b1;
                        ccol       <= clear_colour;
                        cx         <= '0;
                        cy         <= '0;
                        plot       <= 1'b0;
                    end else if (win_valid) begin
                        rr_last    <= win;
                        x_out      <= wx;
                        y_out      <= wy;
                        colour_out <= wc;
                        plot       <= !oor;
                        drop       <= oor;
                    end else begin
                        plot <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    x_out      <= cx;
                    y_out      <= cy;
                    colour_out <= ccol;
                    plot       <= 1'b1;
                    if (cx == X_W'(XMAX)) begin
                        cx <= '0;
                        if (cy == Y_W'(YMAX)) begin
                            cy         <= '0;
                            clear_done <= 1'b1;
                            clear_busy <= 1'b0;
                            state      <= ST_RUN;
                        end else begin
                            cy <= cy + 1'b1;
                        end
                    end else begin
                        cx <= cx + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_plot_arbiter.sv
// Self-checking bench for plot_arbiter: behavioural model checked every cycle,
// plus directed literal checks and randomized requester traffic.
module tb_plot_arbiter;
    import snake_pkg::*;

    localparam int NREQ = 4;
    localparam int XM   = 159;
    localparam int YM   = 119;
    localparam int NPIX = (XM + 1) * (YM + 1);

    logic                clk = 1'b0;
    logic                resetn = 1'b0;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*8-1:0]   req_x = '0;
    logic [NREQ*7-1:0]   req_y = '0;
    logic [NREQ*3-1:0]   req_colour = '0;
    logic [NREQ-1:0]     gnt;
    logic                clear_start = 1'b0;
    logic [2:0]          clear_colour = '0;
    logic                clear_busy;
    logic                clear_done;
    logic [7:0]          x_out;
    logic [6:0]          y_out;
    logic [2:0]          colour_out;
    logic                plot;
    logic                drop;

    plot_arbiter #(
        .NREQ           (NREQ),
        .XMAX           (XM),
        .YMAX           (YM),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req          (req),
        .req_x        (req_x),
        .req_y        (req_y),
        .req_colour   (req_colour),
        .gnt          (gnt),
        .clear_start  (clear_start),
        .clear_colour (clear_colour),
        .clear_busy   (clear_busy),
        .clear_done   (clear_done),
        .x_out        (x_out),
        .y_out        (y_out),
        .colour_out   (colour_out),
        .plot         (plot),
        .drop         (drop)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Behavioural model state
    bit m_clear = 1'b1;
    int m_n = 0, m_ccol = 0, m_rr = NREQ - 1;
    int e_x = 0, e_y = 0, e_c = 0, e_plot = 0, e_drop = 0, e_done = 0, e_busy = 1;

    function automatic int pick();
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (m_rr + k) % NREQ;
            if (req[j]) return j;
        end
        return -1;
    endfunction

    // Compare on the falling edge; then advance the model with the inputs
    // that the next rising edge will sample.
    always @(negedge clk) begin
        int w;
        int eg;
        if (!resetn) begin
            chk("rst_plot", plot, 0);
            chk("rst_x", x_out, 0);
            chk("rst_y", y_out, 0);
            chk("rst_colour", colour_out, 0);
            chk("rst_done", clear_done, 0);
            chk("rst_drop", drop, 0);
            chk("rst_busy", clear_busy, 1);
            chk("rst_gnt", gnt, 0);
            m_clear = 1'b1; m_n = 0; m_ccol = 0; m_rr = NREQ - 1;
            e_x = 0; e_y = 0; e_c = 0; e_plot = 0; e_drop = 0;
            e_done = 0; e_busy = 1;
        end else begin
            w  = pick();
            eg = (m_clear || clear_start || w < 0) ? 0 : (1 << w);
            chk("gnt", gnt, eg);
            chk("plot", plot, e_plot);
            chk("x_out", x_out, e_x);
            chk("y_out", y_out, e_y);
            chk("colour_out", colour_out, e_c);
            chk("drop", drop, e_drop);
            chk("clear_done", clear_done, e_done);
            chk("clear_busy", clear_busy, e_busy);
            if (m_clear) begin
                e_x = m_n % (XM + 1);
                e_y = m_n / (XM + 1);
                e_c = m_ccol;
                e_plot = 1; e_drop = 0;
                e_done = (m_n == NPIX - 1) ? 1 : 0;
                m_n++;
                if (e_done != 0) m_clear = 1'b0;
                e_busy = m_clear ? 1 : 0;
            end else if (clear_start) begin
                m_clear = 1'b1; m_n = 0; m_ccol = clear_colour;
                e_plot = 0; e_drop = 0; e_done = 0; e_busy = 1;
            end else if (w >= 0) begin
                m_rr = w;
                e_x = req_x[8*w +: 8];
                e_y = req_y[7*w +: 7];
                e_c = req_colour[3*w +: 3];
                e_drop = (e_x > XM || e_y > YM) ? 1 : 0;
                e_plot = 1 - e_drop;
                e_done = 0;
            end else begin
                e_plot = 0; e_drop = 0; e_done = 0;
            end
        end
    end

    task automatic set_px(input int i, input int x, input int y, input int c);
        req_x[8*i +: 8]      = 8'(x);
        req_y[7*i +: 7]      = 7'(y);
        req_colour[3*i +: 3] = 3'(c);
    endtask

    task automatic wait_done(input string nm);
        int cnt;
        cnt = 0;
        while (cnt < 20000) begin
            @(posedge clk);
            cnt++;
            #1;
            if (clear_done) break;
        end
        chk(nm, cnt, NPIX);
    endtask

    initial begin
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] seq_exp [5];
        seq_exp[0] = 4'b0001; seq_exp[1] = 4'b0010; seq_exp[2] = 4'b0100;
        seq_exp[3] = 4'b1000; seq_exp[4] = 4'b0001;

        for (int i = 0; i < NREQ; i++) set_px(i, 10 + i, 20 + i, i + 1);
        req = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        chk("lit_rst_busy", clear_busy, 1);
        chk("lit_rst_plot", plot, 0);
        resetn = 1'b1;

        // Interrupt the first clear with an asynchronous reset.
        repeat (1000) @(posedge clk);
        #1;
        chk("lit_pix999_x", x_out, 39);
        chk("lit_pix999_y", y_out, 6);
        chk("lit_pix999_plot", plot, 1);
        resetn = 1'b0;
        #1;
        chk("lit_async_plot", plot, 0);
        chk("lit_async_x", x_out, 0);
        chk("lit_async_y", y_out, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        wait_done("lit_clear_len");
        chk("lit_clear_last_x", x_out, XM);
        chk("lit_clear_last_y", y_out, YM);

        // All four requesting: strict rotation from requester 0.
        for (int k = 0; k < 5; k++) begin
            chk("lit_rr_seq", gnt, seq_exp[k]);
            @(posedge clk);
            #1;
            if (k == 0) chk("lit_rr_pix0_x", x_out, 10);
        end
        req = '0;

        // Single requester, same-cycle grant, next-cycle pixel.
        set_px(2, 50, 70, 7);
        req = 4'b0100;
        #1;
        chk("lit_req2_gnt", gnt, 4'b0100);
        @(posedge clk);
        #1;
        req = '0;
        chk("lit_req2_x", x_out, 50);
        chk("lit_req2_y", y_out, 70);
        chk("lit_req2_c", colour_out, 7);
        chk("lit_req2_plot", plot, 1);

        // Out-of-range pixel is consumed but dropped.
        set_px(1, 160, 5, 2);
        req = 4'b0010;
        #1;
        chk("lit_oor_gnt", gnt, 4'b0010);
        @(posedge clk);
        #1;
        req = '0;
        chk("lit_oor_plot", plot, 0);
        chk("lit_oor_drop", drop, 1);
        @(posedge clk);
        #1;
        chk("lit_oor_drop_pulse", drop, 0);

        // Clear beats a pending request.
        set_px(0, 1, 2, 3);
        req = 4'b0001;
        clear_start = 1'b1;
        clear_colour = 3'b101;
        #1;
        chk("lit_clr_gnt_block", gnt, 0);
        @(posedge clk);
        #1;
        clear_start = 1'b0;
        chk("lit_clr_busy", clear_busy, 1);
        wait_done("lit_clr5_len");
        chk("lit_clr5_colour", colour_out, 5);
        chk("lit_after_clr_gnt", gnt, 4'b0001);
        @(posedge clk);
        #1;
        req = '0;
        chk("lit_after_clr_x", x_out, 1);
        chk("lit_after_clr_busy", clear_busy, 0);

        // Randomized requesters obeying the hold-until-granted rule.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            g = gnt;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && g[i]) begin
                    if ($urandom_range(0, 1) == 1)
                        set_px(i, $urandom_range(0, 175), $urandom_range(0, 127),
                               $urandom_range(0, 7));
                    else
                        req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 9) < 3) begin
                    set_px(i, $urandom_range(0, 175), $urandom_range(0, 127),
                           $urandom_range(0, 7));
                    req[i] = 1'b1;
                end
            end
        end
        req = '0;
        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/plot_arbiter.md
# plot_arbiter

Shares the single pixel-write port of the 160x120, 3-bit-colour VGA adapter among several drawing requesters (snake head draw, tail erase, food draw, score/border). It arbitrates them round-robin, one pixel per cycle. It also contains a full-screen clear engine that takes exclusive ownership of the port. The block sits between the game datapath/control and the VGA adapter's `x`/`y`/`colour`/`plot` inputs.

## Interface
Parameters:
- `NREQ`, 4: number of pixel requesters.
- `XMAX`, 159: last valid x coordinate.
- `YMAX`, 119: last valid y coordinate.
- `CLEAR_ON_RESET`, 1: when 1, a full-screen clear to black starts automatically out of reset.

Ports:
- `clk`, in, 1: clock.
- `resetn`, in, 1: reset; asynchronous, active-low.
- `req`, in, NREQ: per-requester pixel request, held until granted.
- `req_x`, in, NREQ*8: packed x coordinates; requester i uses bits [8i+7:8i].
- `req_y`, in, NREQ*7: packed y coordinates.
- `req_colour`, in, NREQ*3: packed colours.
- `gnt`, out, NREQ: one-hot, combinational; the requester's pixel is consumed at this clock edge.
- `clear_start`, in, 1: single-cycle pulse that starts a full-screen clear.
- `clear_colour`, in, 3: fill colour, latched at clear start.
- `clear_busy`, out, 1: clear engine owns the port.
- `clear_done`, out, 1: one-cycle pulse, coincident with the last clear pixel on the outputs.
- `x_out`, out, 8: pixel x to the adapter.
- `y_out`, out, 7: pixel y to the adapter.
- `colour_out`, out, 3: pixel colour to the adapter.
- `plot`, out, 1: write strobe to the adapter.
- `drop`, out, 1: one-cycle pulse; a granted pixel was out of range and was not plotted.

## Operation
- FSM has two states.
  - RUN: arbitrate requesters.
  - CLEAR: raster fill.
- Reset state:
  - CLEAR if `CLEAR_ON_RESET` = 1, with clear colour 3'b000 and counters at (0,0).
  - RUN otherwise.
- Output reset values: `plot`, `x_out`, `y_out`, `colour_out`, `clear_done` and `drop` are all 0. `clear_busy` resets to `CLEAR_ON_RESET`.
- RUN state:
  - When `clear_start` = 1: `gnt` = 0; at the edge, go to CLEAR, latch `clear_colour`, and zero the counters. Clear beats pending requests.
  - Otherwise, grant at most one requester. Search starts at `rr_last`+1 and wraps modulo NREQ; the first asserted `req` wins.
  - At the grant edge: `rr_last` <= winner; output registers <= the winner's x, y and colour; `plot` <= 1.
  - No request pending: `plot` <= 0, and the x/y/colour outputs hold their values.
- Out-of-range grant (x > XMAX or y > YMAX): the request is still granted and consumed, but `plot` <= 0 and `drop` <= 1.
- CLEAR state:
  - Each edge registers (`cx`, `cy`, latched colour) onto the outputs with `plot` <= 1.
  - Raster order with x fastest: `cx` wraps XMAX→0 and increments `cy`.
  - At the edge that registers (XMAX,YMAX): `clear_done` <= 1 and the FSM returns to RUN.
  - `gnt` is forced to 0 throughout.
  - `clear_start` during CLEAR is ignored.
- `rr_last` resets to NREQ-1, so requester 0 has first priority. `rr_last` is not changed by a clear.
- Coordinate widths are fixed at 8 bits for x and 7 bits for y. Counters compare with `==` against the parameters; no arithmetic overflow is possible.

## Timing
- Arbitration:
  - `gnt` is combinational from `req`, state and `rr_last`, and is valid in the same cycle.
  - Pixel latency is 1 cycle: a request granted at edge E appears on the outputs after E.
  - Throughput is 1 pixel per cycle.
- Requester handshake:
  - After a `gnt` edge, the requester may deassert `req` or present its next pixel.
  - `req`, x, y and colour must be stable while `req` = 1 and `gnt` = 0.
- Clear sequence, with `clear_start` sampled at edge E:
  - `clear_busy` is high for the 19200 cycles after E.
  - The first clear pixel (0,0) is on the outputs after E+1.
  - The last pixel (159,119) is on the outputs after E+19200, together with `clear_done`.
  - The earliest new grant comes in the cycle after E+19200.
- With `CLEAR_ON_RESET` = 1, the first clear pixel appears after the first edge following reset release.
- Asynchronous reset mid-clear or mid-grant drops the operation immediately and returns to the reset state. No partial pixel is issued.

## Structure
- Shared package `snake_pkg`:
  - `X_W` = 8, `Y_W` = 7, `C_W` = 3.
  - `SCREEN_XMAX`, `SCREEN_YMAX`.
  - Colour constants `COL_BLACK` = 3'b000 and `COL_WHITE` = 3'b111.
  - FSM state encoding for `plot_arbiter`.
- One sub-module, `rr_pick`: combinational round-robin winner from `req` and `rr_last`. It outputs one-hot `gnt_raw` and the winner index. `plot_arbiter` ANDs `gnt_raw` with (state == RUN and !`clear_start`).

## Test plan
- Reset with `CLEAR_ON_RESET` = 1 → 19200 consecutive `plot` cycles covering (0,0)…(159,119) in x-fastest order, all colour 0. `clear_done` rises only with (159,119), and no `gnt` fires during the clear.
- `req` = 4'b1111 held constantly after the clear → `gnt` sequence 0001, 0010, 0100, 1000, 0001. Each pixel appears one cycle after its grant.
- `req[2]` alone with (50,70,3'b111) → `gnt[2]` in the same cycle; the next cycle shows `x_out` = 50, `y_out` = 70, `colour_out` = 7, `plot` = 1.
- `clear_start` with `clear_colour` = 3'b101 while `req[0]` is pending → no grant to 0 during the clear; all clear pixels are colour 5. `req[0]` is granted in the cycle after `clear_done`.
- `req[1]` with x = 160, y = 5 → `gnt[1]`, then `plot` = 0 and `drop` = 1 for one cycle.
- `resetn` pulsed low at clear pixel 1000 → all outputs return to their reset values immediately, and the clear restarts from (0,0).
